cache_arbiter: RTL and testbench

Two-port memory arbiter between the instruction cache and the data cache. It shares the single cacheline-wide physical memory port, and sits below both caches and above the cacheline adaptor. It serializes the two miss/writeback streams with round-robin fairness, latches each granted request, and returns a one-cycle response to the owning cache only.

---
 rtl/cache_arbiter_pkg.sv | 16 +
 rtl/cache_arbiter.sv | 113 +++++++++++
 tb/tb_cache_arbiter.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/cache_arbiter_pkg.sv
// Shared types for the I/D cache memory arbiter: FSM states and port identifiers.
package arbiter_types;

  typedef enum logic [1:0] {
    IDLE,
    SERVE_I,
    SERVE_D,
    RELEASE
  } arb_state_t;

  typedef enum logic {
    PORT_I,
    PORT_D
  } arb_port_t;

endpackage

// File: rtl/cache_arbiter.sv
// Round-robin arbiter sharing one cacheline memory port between the I-cache and D-cache.
// One transaction in flight; each grant is latched and held until mem_resp.
module cache_arbiter
  import arbiter_types::*;
#(
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp,
  output arb_state_t        dbg_state
);

  arb_state_t        state;
  arb_port_t         last_grant;
  arb_port_t         pick;
  logic              d_req;
  logic [LINE_W-1:0] i_rdata_q;
  logic [LINE_W-1:0] d_rdata_q;

  // Contested requests go to whichever port was not granted last.
  function automatic arb_port_t pick_port(input logic ireq, input logic dreq,
                                          input arb_port_t last);
    if (ireq && dreq) begin
      if (last == PORT_I) return PORT_D;
      else                return PORT_I;
    end else if (dreq) begin
      return PORT_D;
    end else begin
      return PORT_I;
    end
  endfunction

  assign d_req = d_read | d_write;
  assign pick  = pick_port(i_read, d_req, last_grant);

  // mem_read/mem_write/mem_address/mem_wdata double as the owner register:
  // loaded only on a grant, so live request inputs never reach the memory port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      last_grant  <= PORT_I;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_address <= '0;
      mem_wdata   <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_read || d_req) begin
            last_grant <= pick;
            if (pick == PORT_I) begin
              state       <= SERVE_I;
              mem_read    <= 1'b1;
              mem_write   <= 1'b0;
              mem_address <= i_address;
            end else begin
              state       <= SERVE_D;
              mem_read    <= d_read;
              mem_write   <= d_write;
              mem_address <= d_address;
              mem_wdata   <= d_wdata;
            end
          end
        end
        SERVE_I: begin
          if (mem_resp) begin
            state     <= RELEASE;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            i_rdata_q <= mem_rdata;
          end
        end
        SERVE_D: begin
          if (mem_resp) begin
            state     <= RELEASE;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            d_rdata_q <= mem_rdata;
          end
        end
        RELEASE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Responses are combinational from mem_resp so the cache sees data in the same cycle.
  assign i_resp    = (state == SERVE_I) && mem_resp;
  assign d_resp    = (state == SERVE_D) && mem_resp;
  assign i_rdata   = i_resp ? mem_rdata : i_rdata_q;
  assign d_rdata   = d_resp ? mem_rdata : d_rdata_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter with a response scoreboard and an inline memory model.
module tb_cache_arbiter;
  import arbiter_types::*;

  localparam int LW = 256;
  localparam int AW = 32;

  logic          clk;
  logic          rst_n;
  logic          i_read;
  logic [AW-1:0] i_address;
  logic [LW-1:0] i_rdata;
  logic          i_resp;
  logic          d_read;
  logic          d_write;
  logic [AW-1:0] d_address;
  logic [LW-1:0] d_wdata;
  logic [LW-1:0] d_rdata;
  logic          d_resp;
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_address;
  logic [LW-1:0] mem_wdata;
  logic [LW-1:0] mem_rdata;
  logic          mem_resp;
  arb_state_t    dbg_state;

  int checks = 0;
  int errors = 0;

  logic [LW-1:0] exp_q[$];
  logic          exp_port_q[$];  // 0 = I-cache, 1 = D-cache

  cache_arbiter #(.LINE_W(LW), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .dbg_state(dbg_state)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic port_d, input logic [LW-1:0] data);
    exp_port_q.push_back(port_d);
    exp_q.push_back(data);
  endtask

  // Memory model for one transaction: waits for the grant, checks the latched request
  // stays steady, answers after `latency` cycles and scores the response.
  task automatic mem_txn(input string tag, input logic wr, input logic [AW-1:0] addr,
                         input logic [LW-1:0] wdata, input int latency,
                         input logic [LW-1:0] rdata, input int exp_wait, input bit disturb);
    int            n = 0;
    logic          port_d;
    logic [LW-1:0] exp_data;
    arb_state_t    serve_st;
    while (!(mem_read || mem_write) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!(mem_read || mem_write)) begin
      checks++;
      errors++;
      $error("FAIL %s grant_timeout: observed no mem request expected request within 20 cycles", tag);
      return;
    end
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s scoreboard_empty: observed grant expected none", tag);
      return;
    end
    port_d   = exp_port_q.pop_front();
    exp_data = exp_q.pop_front();
    serve_st = port_d ? SERVE_D : SERVE_I;
    if (exp_wait >= 0) chk({tag, " grant_latency"}, LW'(n), LW'(exp_wait));
    chk({tag, " grant_state"}, LW'(dbg_state), LW'(serve_st));
    if (disturb) i_address = 32'hDEAD_0000;
    for (int k = 0; k < latency; k++) begin
      if (k > 0) @(negedge clk);
      chk({tag, " mem_address"}, LW'(mem_address), LW'(addr));
      chk({tag, " mem_read"}, LW'(mem_read), LW'(!wr));
      chk({tag, " mem_write"}, LW'(mem_write), LW'(wr));
      if (wr) chk({tag, " mem_wdata"}, mem_wdata, wdata);
      chk({tag, " resp_idle"}, LW'({i_resp, d_resp}), LW'(2'b00));
    end
    mem_rdata = rdata;
    mem_resp  = 1'b1;
    #1;
    chk({tag, " owner_resp"}, LW'(port_d ? d_resp : i_resp), LW'(1'b1));
    chk({tag, " other_resp"}, LW'(port_d ? i_resp : d_resp), LW'(1'b0));
    chk({tag, " rdata_bypass"}, port_d ? d_rdata : i_rdata, exp_data);
    @(negedge clk);
    mem_resp  = 1'b0;
    mem_rdata = '0;
    #1;
    chk({tag, " resp_pulse_end"}, LW'({i_resp, d_resp}), LW'(2'b00));
    chk({tag, " release_ctrl"}, LW'({mem_read, mem_write}), LW'(2'b00));
    chk({tag, " release_state"}, LW'(dbg_state), LW'(RELEASE));
    chk({tag, " rdata_held"}, port_d ? d_rdata : i_rdata, exp_data);
  endtask

  initial begin
    logic [LW-1:0] pat_a5;
    logic [LW-1:0] pat_1234;
    pat_a5   = {32{8'hA5}};
    pat_1234 = {16{16'h1234}};

    // Reset state.
    rst_n = 1'b0; i_read = 1'b0; i_address = '0; d_read = 1'b0; d_write = 1'b0;
    d_address = '0; d_wdata = '0; mem_rdata = '0; mem_resp = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset mem_ctrl", LW'({mem_read, mem_write}), LW'(2'b00));
    chk("reset mem_address", LW'(mem_address), LW'(0));
    chk("reset mem_wdata", mem_wdata, '0);
    chk("reset resp", LW'({i_resp, d_resp}), LW'(2'b00));
    chk("reset i_rdata", i_rdata, '0);
    chk("reset d_rdata", d_rdata, '0);
    chk("reset state", LW'(dbg_state), LW'(IDLE));
    rst_n = 1'b1;

    // I-only read of 0x1000, memory answers with A5 after 5 cycles.
    @(negedge clk);
    i_read = 1'b1; i_address = 32'h0000_1000;
    push_exp(1'b0, pat_a5);
    mem_txn("i_read", 1'b0, 32'h0000_1000, '0, 5, pat_a5, 1, 1'b0);
    i_read = 1'b0;
    @(negedge clk);
    chk("i_read back_to_idle", LW'(dbg_state), LW'(IDLE));

    // D writeback of 0x2040 with 0x1234 pattern.
    d_write = 1'b1; d_address = 32'h0000_2040; d_wdata = pat_1234;
    push_exp(1'b1, {LW{1'b1}});
    mem_txn("d_write", 1'b1, 32'h0000_2040, pat_1234, 3, {LW{1'b1}}, 1, 1'b0);
    d_write = 1'b0; d_wdata = '0;
    @(negedge clk);

    // I address changes mid-transaction; the latched address must persist.
    i_read = 1'b1; i_address = 32'h0000_1040;
    push_exp(1'b0, {8{32'hCAFE_0001}});
    mem_txn("i_latch", 1'b0, 32'h0000_1040, '0, 4, {8{32'hCAFE_0001}}, 1, 1'b1);
    i_read = 1'b0; i_address = '0;
    @(negedge clk);

    // D read held one cycle past d_resp: RELEASE absorbs it, no second grant.
    d_read = 1'b1; d_address = 32'h0000_5000;
    push_exp(1'b1, {4{64'h0123_4567_89AB_CDEF}});
    mem_txn("d_hold", 1'b0, 32'h0000_5000, '0, 2, {4{64'h0123_4567_89AB_CDEF}}, 1, 1'b0);
    @(negedge clk);
    d_read = 1'b0;
    #1;
    chk("d_hold idle_state", LW'(dbg_state), LW'(IDLE));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("d_hold no_regrant", LW'({mem_read, mem_write}), LW'(2'b00));
    end

    // Reset while SERVE_D waits: controls drop at once and no response reaches the owner.
    d_read = 1'b1; d_address = 32'h0000_6000;
    @(negedge clk);
    chk("rst_mid grant", LW'(mem_read), LW'(1'b1));
    rst_n = 1'b0;
    #1;
    chk("rst_mid mem_ctrl", LW'({mem_read, mem_write}), LW'(2'b00));
    chk("rst_mid mem_address", LW'(mem_address), LW'(0));
    chk("rst_mid state", LW'(dbg_state), LW'(IDLE));
    mem_resp = 1'b1; mem_rdata = pat_a5;
    #1;
    chk("rst_mid no_resp", LW'({i_resp, d_resp}), LW'(2'b00));
    chk("rst_mid d_rdata", d_rdata, '0);
    @(negedge clk);
    mem_resp = 1'b0; mem_rdata = '0; d_read = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Contested grants from reset with both held: D, I, D, I with 3-cycle turnaround.
    i_read = 1'b1; i_address = 32'h0000_3000;
    d_read = 1'b1; d_address = 32'h0000_4000;
    push_exp(1'b1, {8{32'h0000_D001}});
    push_exp(1'b0, {8{32'h0000_1001}});
    push_exp(1'b1, {8{32'h0000_D002}});
    push_exp(1'b0, {8{32'h0000_1002}});
    mem_txn("rr0_d", 1'b0, 32'h0000_4000, '0, $urandom_range(1, 4), {8{32'h0000_D001}}, 1, 1'b0);
    mem_txn("rr1_i", 1'b0, 32'h0000_3000, '0, $urandom_range(1, 4), {8{32'h0000_1001}}, 2, 1'b0);
    mem_txn("rr2_d", 1'b0, 32'h0000_4000, '0, $urandom_range(1, 4), {8{32'h0000_D002}}, 2, 1'b0);
    mem_txn("rr3_i", 1'b0, 32'h0000_3000, '0, $urandom_range(1, 4), {8{32'h0000_1002}}, 2, 1'b0);
    i_read = 1'b0; d_read = 1'b0;
    repeat (2) @(negedge clk);
    chk("rr idle_after", LW'({mem_read, mem_write}), LW'(2'b00));
    chk("scoreboard drained", LW'(exp_q.size()), LW'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
